// File: rtl/aes_key_mem_mc.sv
// aes_key_mem_mc: multi-context AES key-schedule memory.
// Expands an AES-128 or AES-256 key, one round key per cycle, into one of
// NUM_SLOTS slots. Every slot can be read back at any time.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   zeroize           (only with AES_KEY_ZEROIZE_EN) wipe all slots
//   key, keylen       cipher key (AES-128 uses key[255:128]); 2'b00=128, 2'b10=256
//   init, init_slot   single-cycle expansion request and target slot
//   rd_slot, round    read address; round_key is the combinational read data
//   ready             idle and the last accepted expansion has completed
//   busy              FSM is not in IDLE
//   slot_valid        per-slot "complete schedule present"
//   err               one-cycle pulse on a rejected/ignored request
//
// Optional feature macro: AES_KEY_ZEROIZE_EN adds the zeroize input.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for an accepted init
// INIT     | clear round counter, load rcon seed
// GENERATE | write one round key per cycle; one extra cycle to finish
// DONE     | mark slot valid, raise ready
module aes_key_mem_mc #(
    parameter int NUM_SLOTS = 2,
    parameter int SLOT_W    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic                 zeroize,
`endif
    input  logic [255:0]         key,
    input  logic [1:0]           keylen,
    input  logic                 init,
    input  logic [SLOT_W-1:0]    init_slot,
    input  logic [SLOT_W-1:0]    rd_slot,
    input  logic [3:0]           round,
    output logic [127:0]         round_key,
    output logic                 ready,
    output logic                 busy,
    output logic [NUM_SLOTS-1:0] slot_valid,
    output logic                 err
);

    typedef enum logic [1:0] {IDLE, INIT, GENERATE, DONE} state_t;

    localparam logic [SLOT_W:0] NUM_SLOTS_L = (SLOT_W + 1)'(NUM_SLOTS);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t              state;
    logic [255:0]        key_q;
    logic                is256_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [3:0]          cnt;
    logic [7:0]          rcon;
    logic [127:0]        prev1;      // most recently generated round key
    logic [127:0]        prev2;      // the one before it (AES-256 only)
    logic [127:0]        mem [NUM_SLOTS][15];
    logic [NUM_SLOTS-1:0] slot_256;

    logic                init_ok;
    logic [3:0]          last_rnd;
    logic [31:0]         temp;
    logic [127:0]        base;
    logic [31:0]         w0, w1, w2, w3;
    logic [127:0]        new_key;
    logic                rcon_adv;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign init_ok = ((keylen == 2'b00) || (keylen == 2'b10)) &&
                     ({1'b0, init_slot} < NUM_SLOTS_L);

    // Next round key from the previous one (AES-128) or previous two (AES-256).
    always_comb begin
        last_rnd = is256_q ? 4'd14 : 4'd10;
        temp     = 32'h0;
        base     = is256_q ? prev2 : prev1;
        if (is256_q && cnt[0])
            temp = subword(prev1[31:0]);
        else
            temp = subword({prev1[23:0], prev1[31:24]}) ^ {rcon, 24'h0};
        w0 = base[127:96] ^ temp;
        w1 = base[95:64]  ^ w0;
        w2 = base[63:32]  ^ w1;
        w3 = base[31:0]   ^ w2;
        if (cnt == 4'd0)
            new_key = key_q[255:128];
        else if (is256_q && (cnt == 4'd1))
            new_key = key_q[127:0];
        else
            new_key = {w0, w1, w2, w3};
        rcon_adv = is256_q ? cnt[0] : (cnt <= 4'd9);
    end

    always_comb begin
        round_key = 128'h0;
        if (({1'b0, rd_slot} < NUM_SLOTS_L) && slot_valid[rd_slot] &&
            (round <= (slot_256[rd_slot] ? 4'd14 : 4'd10)))
            round_key = mem[rd_slot][round];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ready      <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            slot_valid <= '0;
            slot_256   <= '0;
            cnt        <= 4'd0;
            rcon       <= 8'h00;
            key_q      <= '0;
            is256_q    <= 1'b0;
            slot_q     <= '0;
            prev1      <= '0;
            prev2      <= '0;
            for (int s = 0; s < NUM_SLOTS; s++)
                for (int r = 0; r < 15; r++)
                    mem[s][r] <= '0;
        end
`ifdef AES_KEY_ZEROIZE_EN
        else if (zeroize) begin
            state      <= IDLE;
            ready      <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            slot_valid <= '0;
            cnt        <= 4'd0;
            rcon       <= 8'h00;
            key_q      <= '0;
            prev1      <= '0;
            prev2      <= '0;
            for (int s = 0; s < NUM_SLOTS; s++)
                for (int r = 0; r < 15; r++)
                    mem[s][r] <= '0;
        end
`endif
        else begin
            // Any init not accepted from IDLE is flagged, including during expansion.
            err <= init && ((state != IDLE) || !init_ok);
            case (state)
                IDLE: begin
                    if (init && init_ok) begin
                        key_q               <= key;
                        is256_q             <= keylen[1];
                        slot_q              <= init_slot;
                        slot_256[init_slot] <= keylen[1];
                        slot_valid[init_slot] <= 1'b0;
                        ready               <= 1'b0;
                        busy                <= 1'b1;
                        state               <= INIT;
                    end
                end
                INIT: begin
                    cnt   <= 4'd0;
                    rcon  <= 8'h8d;
                    state <= GENERATE;
                end
                GENERATE: begin
                    // Counter one past the last round: all keys are written.
                    if (cnt == last_rnd + 4'd1) begin
                        state <= DONE;
                    end else begin
                        mem[slot_q][cnt] <= new_key;
                        prev2            <= prev1;
                        prev1            <= new_key;
                        if (rcon_adv)
                            rcon <= xtime(rcon);
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    slot_valid[slot_q] <= 1'b1;
                    ready              <= 1'b1;
                    busy               <= 1'b0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_mem_mc.sv
// Self-checking bench for aes_key_mem_mc (3 slots, 2-bit slot index, so an
// out-of-range slot is reachable). Reference model follows the FIPS-197
// word-wise key expansion with an S-box derived from GF(2^8) inversion.
module tb_aes_key_mem_mc;
    localparam int NS = 3;

    logic         clk = 1'b0;
    logic         rst_n;
`ifdef AES_KEY_ZEROIZE_EN
    logic         zeroize;
`endif
    logic [255:0] key;
    logic [1:0]   keylen;
    logic         init;
    logic [1:0]   init_slot;
    logic [1:0]   rd_slot;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;
    logic         busy;
    logic [NS-1:0] slot_valid;
    logic         err;

    always #5 clk = ~clk;

    aes_key_mem_mc #(.NUM_SLOTS(NS), .SLOT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .key(key), .keylen(keylen), .init(init), .init_slot(init_slot),
        .rd_slot(rd_slot), .round(round), .round_key(round_key),
        .ready(ready), .busy(busy), .slot_valid(slot_valid), .err(err)
    );

    int checks = 0;
    int errors = 0;

    // reference model
    logic [7:0]   sb [256];
    logic         mvalid [4];
    logic         m256 [4];
    logic [127:0] msched [4][16];
    logic         mready;

    typedef struct {
        logic         do_exp;
        logic [255:0] k;
        logic         is256;
        int           slot;
        int           rnd;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs[14];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h0; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] exp_read(input int s, input int r);
        if (s >= NS || !mvalid[s]) return 128'h0;
        if (r > (m256[s] ? 14 : 10)) return 128'h0;
        return msched[s][r];
    endfunction

    task automatic model_expand(input int s, input logic is256, input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nr;
        nk = is256 ? 8 : 4;
        nr = is256 ? 14 : 10;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            msched[s][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
        m256[s] = is256;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic chk_read(input int s, input int r);
        rd_slot = 2'(s); round = 4'(r); #1;
        chk($sformatf("read s%0d r%0d", s, r), round_key, exp_read(s, r));
    endtask

    task automatic chk_read_rand;
        chk_read($urandom_range(0, 3), $urandom_range(0, 15));
    endtask

    task automatic chk_all_reads;
        for (int s = 0; s < 4; s++)
            for (int r = 0; r < 16; r++)
                chk_read(s, r);
    endtask

    task automatic chk_status(input string nm);
        logic [NS-1:0] sv;
        for (int s = 0; s < NS; s++) sv[s] = mvalid[s];
        chk({nm, " slot_valid"}, slot_valid, sv);
        chk({nm, " ready"}, ready, mready);
    endtask

    // intrude >= 0: issue a second init that gets sampled intrude+1 cycles after the first
    task automatic expand(input int s, input logic is256, input logic [255:0] k, input int intrude);
        int n;
        key = k; keylen = is256 ? 2'b10 : 2'b00; init_slot = 2'(s); init = 1'b1;
        tick;
        init = 1'b0;
        mvalid[s] = 1'b0; mready = 1'b0;
        chk("busy after accept", busy, 1);
        chk_status("accept");
        n = 0;
        while (!ready && n < 40) begin
            chk_read_rand();
            if (n == intrude) begin
                init = 1'b1; key = ~k; keylen = 2'b10; init_slot = 2'((s + 1) % NS);
            end
            tick;
            n++;
            if (n == intrude + 1) begin
                init = 1'b0;
                chk("err on busy init", err, 1);
                chk("busy during intrusion", busy, 1);
            end
        end
        chk("ready latency", n, is256 ? 18 : 14);
        model_expand(s, is256, k);
        mvalid[s] = 1'b1; mready = 1'b1;
        chk_status("done");
        chk("busy after done", busy, 0);
    endtask

    task automatic reject(input int s, input logic [1:0] kl, input logic [255:0] k);
        key = k; keylen = kl; init_slot = 2'(s); init = 1'b1;
        tick;
        init = 1'b0;
        chk("err pulse", err, 1);
        chk("busy on reject", busy, 0);
        chk_status("reject");
        tick;
        chk("err one cycle", err, 0);
    endtask

    task automatic model_clear;
        for (int s = 0; s < 4; s++) begin
            mvalid[s] = 1'b0; m256[s] = 1'b0;
            for (int r = 0; r < 16; r++) msched[s][r] = 128'h0;
        end
        mready = 1'b0;
    endtask

    initial begin
        logic [7:0]   inv;
        logic [255:0] rk;
        int           rs, rl;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        model_clear();

        vecs[0]  = '{1, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 0, 0, 1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
        vecs[1]  = '{0, 256'h0, 0, 0, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[2]  = '{0, 256'h0, 0, 0, 0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[3]  = '{0, 256'h0, 0, 0, 11, 128'h0};
        vecs[4]  = '{1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1, 1, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
        vecs[5]  = '{0, 256'h0, 0, 1, 1,  128'h101112131415161718191a1b1c1d1e1f};
        vecs[6]  = '{0, 256'h0, 0, 1, 2,  128'ha573c29fa176c498a97fce93a572c09c};
        vecs[7]  = '{0, 256'h0, 0, 1, 3,  128'h1651a8cd0244beda1a5da4c10640bade};
        vecs[8]  = '{0, 256'h0, 0, 1, 15, 128'h0};
        vecs[9]  = '{0, 256'h0, 0, 0, 1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
        vecs[10] = '{0, 256'h0, 0, 2, 0,  128'h0};
        vecs[11] = '{0, 256'h0, 0, 3, 0,  128'h0};
        vecs[12] = '{1, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0, 2, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[13] = '{0, 256'h0, 0, 2, 1,  128'ha0fafe1788542cb123a339392a6c7605};

        rst_n = 1'b0; init = 1'b0; key = '0; keylen = 2'b00;
        init_slot = 2'd0; rd_slot = 2'd0; round = 4'd0;
`ifdef AES_KEY_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        chk("reset busy", busy, 0);
        chk("reset err", err, 0);
        chk_status("reset");
        chk_read(0, 0);
        chk_read(1, 5);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].do_exp) expand(vecs[i].slot, vecs[i].is256, vecs[i].k, -1);
            rd_slot = 2'(vecs[i].slot); round = 4'(vecs[i].rnd); #1;
            chk($sformatf("vector %0d", i), round_key, vecs[i].exp);
        end

        reject(0, 2'b01, {8{32'h5a5a1234}});
        reject(1, 2'b11, {8{32'hdeadbeef}});
        reject(3, 2'b00, {8{32'h01234567}});
        chk_read(0, 1);

        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        expand(0, 1'b0, rk, 4);
        for (int r = 0; r < 16; r++) chk_read(0, r);
        chk_read(1, 14);

        // reset while slot 2 is mid-generation
        key = {$urandom, $urandom, $urandom, $urandom, 128'h0}; keylen = 2'b00;
        init_slot = 2'd2; init = 1'b1;
        tick;
        init = 1'b0;
        repeat (6) tick;
        chk("busy before abort", busy, 1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        model_clear();
        chk("busy after abort", busy, 0);
        chk_status("abort");
        chk_all_reads();
        expand(2, 1'b1, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, -1);
        for (int r = 0; r < 16; r++) chk_read(2, r);

        for (int it = 0; it < 10; it++) begin
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rs = $urandom_range(0, 3);
            rl = $urandom_range(0, 3);
            if ((rl == 0 || rl == 2) && rs < NS) expand(rs, rl == 2, rk, -1);
            else reject(rs, 2'(rl), rk);
            repeat (16) chk_read_rand();
        end

`ifdef AES_KEY_ZEROIZE_EN
        expand(0, 1'b0, {$urandom, $urandom, $urandom, $urandom, 128'h0}, -1);
        expand(1, 1'b1, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, -1);
        zeroize = 1'b1;
        key = '1; keylen = 2'b00; init_slot = 2'd2; init = 1'b1;
        tick;
        zeroize = 1'b0; init = 1'b0;
        model_clear();
        chk("busy after zeroize", busy, 0);
        chk_status("zeroize");
        chk_all_reads();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
